// File: rtl/scheduler_acc_lookup_pkg.sv
// Scheduling-data layout shared between the bitinfo parse stage and the accelerator lookup.
package scheduler_acc_lookup_pkg;
  localparam int MAX_ACCS               = 16;
  localparam int ACC_BITS               = $clog2(MAX_ACCS);
  localparam int SCHED_DATA_W           = 50;
  localparam int SCHED_DATA_TASK_TYPE_L = 16;
  localparam int SCHED_DATA_TASK_TYPE_H = 49;
  localparam int SCHED_DATA_COUNT_L     = 8;
  localparam int SCHED_DATA_ACCID_L     = 0;
  localparam int TASK_TYPE_W            = SCHED_DATA_TASK_TYPE_H - SCHED_DATA_TASK_TYPE_L + 1;
endpackage

// File: rtl/scheduler_acc_lookup_rr_counters.sv
// Per-entry round-robin counters: combined select (base + rr[idx]) and wrap-at-count advance.
module scheduler_acc_lookup_rr_counters
  import scheduler_acc_lookup_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ACC_BITS-1:0] idx,
  input  logic [ACC_BITS-1:0] count,
  input  logic [ACC_BITS-1:0] base,
  input  logic                advance,
  output logic [ACC_BITS-1:0] acc_id
);
  logic [ACC_BITS-1:0] rr [MAX_ACCS];

  assign acc_id = base + rr[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_ACCS; i++) rr[i] <= '0;
    end else if (advance) begin
      rr[idx] <= (rr[idx] == count) ? '0 : rr[idx] + {{(ACC_BITS-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/scheduler_acc_lookup.sv
// Task-type to accelerator-id lookup over the scheduling-data memory with round-robin selection.
// Optional last-hit cache enabled by defining SCHED_LOOKUP_CACHE_EN.
module scheduler_acc_lookup
  import scheduler_acc_lookup_pkg::*;
(
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic                    sched_ready,
  input  logic [ACC_BITS:0]       sched_num_types,
  output logic [ACC_BITS-1:0]     scheduleData_address0,
  output logic                    scheduleData_ce0,
  input  logic [SCHED_DATA_W-1:0] scheduleData_q0,
  input  logic [TASK_TYPE_W-1:0]  req_task_type,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_found,
  output logic [ACC_BITS-1:0]     rsp_acc_id
);
  typedef enum logic [1:0] {IDLE, READ, CHECK, RESP} state_t;

  state_t                 state, state_next;
  logic [ACC_BITS-1:0]    idx;
  logic [TASK_TYPE_W-1:0] type_r;
  logic [TASK_TYPE_W-1:0] entry_type;
  logic [ACC_BITS-1:0]    entry_count, entry_base;
  logic [ACC_BITS:0]      idx_plus1;
  logic                   accept, check_hit, last_entry, cache_hit;
  logic [ACC_BITS-1:0]    sel_idx, sel_count, sel_base, sel_acc;
  logic                   unused_bits;

  assign entry_type  = scheduleData_q0[SCHED_DATA_TASK_TYPE_H:SCHED_DATA_TASK_TYPE_L];
  assign entry_count = scheduleData_q0[SCHED_DATA_COUNT_L +: ACC_BITS];
  assign entry_base  = scheduleData_q0[SCHED_DATA_ACCID_L +: ACC_BITS];
  assign unused_bits = ^{scheduleData_q0[SCHED_DATA_TASK_TYPE_L-1:SCHED_DATA_COUNT_L+ACC_BITS],
                         scheduleData_q0[SCHED_DATA_COUNT_L-1:SCHED_DATA_ACCID_L+ACC_BITS]};

  assign req_ready             = (state == IDLE) && sched_ready;
  assign accept                = req_valid && req_ready;
  assign scheduleData_ce0      = (state == READ);
  assign scheduleData_address0 = (state == READ) ? idx : '0;
  assign check_hit             = (state == CHECK) && (entry_type == type_r);
  assign idx_plus1             = {1'b0, idx} + {{ACC_BITS{1'b0}}, 1'b1};
  assign last_entry            = (idx_plus1 == sched_num_types);

`ifdef SCHED_LOOKUP_CACHE_EN
  logic                   cache_valid;
  logic [TASK_TYPE_W-1:0] cache_type;
  logic [ACC_BITS-1:0]    cache_idx, cache_base, cache_count;

  assign cache_hit = accept && cache_valid && (cache_type == req_task_type);
  assign sel_idx   = cache_hit ? cache_idx   : idx;
  assign sel_count = cache_hit ? cache_count : entry_count;
  assign sel_base  = cache_hit ? cache_base  : entry_base;

  // Any drop of sched_ready may mean the memory is being refilled, so the cache is invalidated.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || !sched_ready) cache_valid <= 1'b0;
    else if (check_hit)         cache_valid <= 1'b1;
    if (check_hit) begin
      cache_type  <= type_r;
      cache_idx   <= idx;
      cache_base  <= entry_base;
      cache_count <= entry_count;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign sel_idx   = idx;
  assign sel_count = entry_count;
  assign sel_base  = entry_base;
`endif

  scheduler_acc_lookup_rr_counters u_sched_rr_counters (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .idx     (sel_idx),
    .count   (sel_count),
    .base    (sel_base),
    .advance (check_hit || cache_hit),
    .acc_id  (sel_acc)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (cache_hit || sched_num_types == '0) ? RESP : READ;
      READ:    state_next = CHECK;
      CHECK:   if (check_hit || last_entry) state_next = RESP;
               else                         state_next = READ;
      RESP:    if (rsp_valid && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rsp_valid rises on the first RESP edge so found/acc_id are already settled when it appears.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      idx        <= '0;
      rsp_valid  <= 1'b0;
      rsp_found  <= 1'b0;
      rsp_acc_id <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          type_r     <= req_task_type;
          idx        <= '0;
          rsp_found  <= cache_hit;
          rsp_acc_id <= cache_hit ? sel_acc : '0;
        end
        CHECK: begin
          if (check_hit) begin
            rsp_found  <= 1'b1;
            rsp_acc_id <= sel_acc;
          end else if (last_entry) begin
            rsp_found  <= 1'b0;
            rsp_acc_id <= '0;
          end else begin
            idx <= idx_plus1[ACC_BITS-1:0];
          end
        end
        RESP: begin
          if (!rsp_valid)     rsp_valid <= 1'b1;
          else if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scheduler_acc_lookup.sv
// Scoreboard bench for scheduler_acc_lookup; define SCHED_LOOKUP_CACHE_EN to also cover the cache.
module tb_scheduler_acc_lookup;
  import scheduler_acc_lookup_pkg::*;

`ifdef SCHED_LOOKUP_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic                    ap_clk = 1'b0;
  logic                    ap_rst = 1'b1;
  logic                    sched_ready = 1'b1;
  logic [ACC_BITS:0]       sched_num_types = '0;
  logic [ACC_BITS-1:0]     scheduleData_address0;
  logic                    scheduleData_ce0;
  logic [SCHED_DATA_W-1:0] scheduleData_q0 = '0;
  logic [TASK_TYPE_W-1:0]  req_task_type = '0;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b1;
  logic                    rsp_found;
  logic [ACC_BITS-1:0]     rsp_acc_id;

  scheduler_acc_lookup dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .sched_ready           (sched_ready),
    .sched_num_types       (sched_num_types),
    .scheduleData_address0 (scheduleData_address0),
    .scheduleData_ce0      (scheduleData_ce0),
    .scheduleData_q0       (scheduleData_q0),
    .req_task_type         (req_task_type),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_found             (rsp_found),
    .rsp_acc_id            (rsp_acc_id)
  );

  always #5 ap_clk = ~ap_clk;

  logic [SCHED_DATA_W-1:0] mem [MAX_ACCS];
  always @(posedge ap_clk) if (scheduleData_ce0) scheduleData_q0 <= mem[scheduleData_address0];

  typedef struct {
    logic                found;
    logic [ACC_BITS-1:0] id;
    int                  lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [SCHED_DATA_W-1:0] entry(input int t, input int base, input int count);
    return {34'(t), 8'(count), 8'(base)};
  endfunction

  function automatic int lat_of(input int scan, input bit cached);
    return (CACHE_ON && cached) ? 1 : scan;
  endfunction

  function automatic void push_exp(input logic f, input int id, input int lat);
    exp_t e;
    e.found = f;
    e.id    = ACC_BITS'(id);
    e.lat   = lat;
    sb.push_back(e);
  endfunction

  task automatic load_mem_a();
    for (int i = 0; i < MAX_ACCS; i++) mem[i] = '0;
    mem[0] = entry(5, 0, 1);
    mem[1] = entry(7, 2, 2);
    sched_num_types = 2;
  endtask

  // Drives one request and reports what the DUT returned; lat = -1 if accept or response never came.
  task automatic send_req(input int t, output logic f, output logic [ACC_BITS-1:0] id, output int lat);
    bit acc;
    acc = 1'b0;
    f   = 1'bx;
    id  = 'x;
    lat = -1;
    @(negedge ap_clk);
    req_task_type = 34'(t);
    req_valid     = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge ap_clk);
    end
    if (!acc) begin req_valid = 1'b0; return; end
    @(posedge ap_clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin lat = i; f = rsp_found; id = rsp_acc_id; break; end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_tests++; if (rsp_found !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_found got %b want 0", rsp_found); end
    n_tests++; if (rsp_acc_id !== '0) begin n_fail++; $display("FAIL reset_rsp_acc_id got %0d want 0", rsp_acc_id); end
    n_tests++; if (scheduleData_ce0 !== 1'b0) begin n_fail++; $display("FAIL reset_ce0 got %b want 0", scheduleData_ce0); end
    n_tests++; if (scheduleData_address0 !== '0) begin n_fail++; $display("FAIL reset_address0 got %0d want 0", scheduleData_address0); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    ap_rst = 1'b0;
  endtask

  task automatic test_hit_rr();
    int ids [4] = '{2, 3, 4, 2};
    logic f; logic [ACC_BITS-1:0] id; int lat; exp_t e;
    load_mem_a();
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b1, ids[i], lat_of(5, i != 0));
      send_req(7, f, id, lat);
      e = sb.pop_front();
      n_tests++;
      if (f !== e.found || id !== e.id || lat != e.lat) begin
        n_fail++;
        $display("FAIL hit_rr[%0d] got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", i, f, id, lat, e.found, e.id, e.lat);
      end
    end
  endtask

  task automatic test_miss();
    logic f; logic [ACC_BITS-1:0] id; int lat; exp_t e;
    push_exp(1'b0, 0, 5);
    send_req(9, f, id, lat);
    e = sb.pop_front();
    n_tests++;
    if (f !== e.found || id !== e.id || lat != e.lat) begin
      n_fail++;
      $display("FAIL miss got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", f, id, lat, e.found, e.id, e.lat);
    end
  endtask

  task automatic test_empty();
    logic f; logic [ACC_BITS-1:0] id; int lat; exp_t e;
    sched_num_types = 0;
    push_exp(1'b0, 0, 1);
    send_req(3, f, id, lat);
    e = sb.pop_front();
    n_tests++;
    if (f !== e.found || id !== e.id || lat != e.lat) begin
      n_fail++;
      $display("FAIL empty got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", f, id, lat, e.found, e.id, e.lat);
    end
    @(negedge ap_clk);
    sched_ready   = 1'b0;
    req_task_type = 34'd7;
    req_valid     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ap_clk);
      n_tests++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL not_ready[%0d] got req_ready=%b rsp_valid=%b want 0 0", i, req_ready, rsp_valid);
      end
    end
    req_valid       = 1'b0;
    sched_ready     = 1'b1;
    sched_num_types = 2;
  endtask

  task automatic test_hold_and_reset();
    logic f; logic [ACC_BITS-1:0] id; int lat; exp_t e;
    rsp_ready = 1'b0;
    push_exp(1'b1, 3, 5);
    send_req(7, f, id, lat);
    e = sb.pop_front();
    n_tests++;
    if (f !== e.found || id !== e.id || lat != e.lat) begin
      n_fail++;
      $display("FAIL hold_rsp got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", f, id, lat, e.found, e.id, e.lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_acc_id !== e.id || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d] got valid=%b id=%0d req_ready=%b want 1 %0d 0", i, rsp_valid, rsp_acc_id, req_ready, e.id);
      end
    end
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_task_type = 34'd7;
    req_valid     = 1'b1;
    @(posedge ap_clk); #1;
    req_valid = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    n_tests++;
    if (rsp_valid !== 1'b0 || scheduleData_ce0 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_scan_reset got rsp_valid=%b ce0=%b want 0 0", rsp_valid, scheduleData_ce0);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    push_exp(1'b1, 2, 5);
    send_req(7, f, id, lat);
    e = sb.pop_front();
    n_tests++;
    if (f !== e.found || id !== e.id || lat != e.lat) begin
      n_fail++;
      $display("FAIL rr_after_reset got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", f, id, lat, e.found, e.id, e.lat);
    end
  endtask

  task automatic test_duplicate();
    int ids [3] = '{0, 1, 0};
    logic f; logic [ACC_BITS-1:0] id; int lat; exp_t e;
    mem[0] = entry(5, 0, 1);
    mem[1] = entry(5, 8, 0);
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, ids[i], lat_of(3, i != 0));
      send_req(5, f, id, lat);
      e = sb.pop_front();
      n_tests++;
      if (f !== e.found || id !== e.id || lat != e.lat) begin
        n_fail++;
        $display("FAIL duplicate[%0d] got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", i, f, id, lat, e.found, e.id, e.lat);
      end
    end
  endtask

`ifdef SCHED_LOOKUP_CACHE_EN
  task automatic test_cache();
    int ids  [3] = '{2, 3, 4};
    int lats [3] = '{5, 1, 5};
    logic f; logic [ACC_BITS-1:0] id; int lat; exp_t e;
    load_mem_a();
    @(negedge ap_clk); ap_rst = 1'b1;
    @(negedge ap_clk); ap_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(negedge ap_clk); sched_ready = 1'b0;
        @(negedge ap_clk); sched_ready = 1'b1;
      end
      push_exp(1'b1, ids[i], lats[i]);
      send_req(7, f, id, lat);
      e = sb.pop_front();
      n_tests++;
      if (f !== e.found || id !== e.id || lat != e.lat) begin
        n_fail++;
        $display("FAIL cache[%0d] got found=%b id=%0d lat=%0d want found=%b id=%0d lat=%0d", i, f, id, lat, e.found, e.id, e.lat);
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MAX_ACCS; i++) mem[i] = '0;
    test_reset();
    test_hit_rr();
    test_miss();
    test_empty();
    test_hold_and_reset();
    test_duplicate();
`ifdef SCHED_LOOKUP_CACHE_EN
    test_cache();
`endif
    repeat (2) @(posedge ap_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/scheduler_acc_lookup.md
Name: scheduler_acc_lookup

Overview:
- Downstream consumer of the scheduling-data memory that the bitinfo parse stage fills.
- Takes a task-type request and linearly scans the entries for a matching task type.
- Returns one accelerator id from that type's instance range, chosen round-robin.
- Sits between the new-task path and the accelerator dispatch logic of the extended scheduler.

Parameters:
- MAX_ACCS, 16, maximum accelerators and maximum scheduling entries; taken from the OmpSsManager package.
- ACC_BITS, $clog2(MAX_ACCS), width of accelerator ids and entry indices; derived, not overridable.

Ports:
- ap_clk  in  1  single clock; all logic on its rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- sched_ready  in  1  parse stage finished; the memory contents are valid.
- sched_num_types  in  ACC_BITS+1  number of valid entries, 0..MAX_ACCS.
- scheduleData_address0  out  ACC_BITS  memory read address.
- scheduleData_ce0  out  1  memory read enable.
- scheduleData_q0  in  50  memory read data, valid the cycle after ce0.
- req_task_type  in  34  requested task type.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_found  out  1  1 = a matching entry exists.
- rsp_acc_id  out  ACC_BITS  selected accelerator id; 0 when rsp_found=0.

Behaviour:
- Entry layout in the 50-bit word:
  - [49:16] task type.
  - [15:8] count, stored as instances-1; only the low ACC_BITS bits are used.
  - [7:0] first accelerator id; only the low ACC_BITS bits are used.
- Reset (ap_rst=1 at a clock edge) does all of the following:
  - state goes to IDLE;
  - rsp_valid=0, rsp_found=0, rsp_acc_id=0;
  - scheduleData_ce0=0, scheduleData_address0=0;
  - every round-robin counter rr[0..MAX_ACCS-1] is cleared to 0;
  - any request in progress is abandoned.
- req_ready = (state==IDLE) && sched_ready.
- scheduleData_ce0 is high only in READ.
- States and transitions:
  - IDLE: on accept, latch req_task_type and set idx=0. If sched_num_types==0, go to RESP with found=0; otherwise go to READ.
  - READ: drive address0=idx and ce0=1; go to CHECK.
  - CHECK: compare q0[49:16] with the latched type.
    - Match: set found=1; acc_id = q0[7:0] + rr[idx], truncated to ACC_BITS. Update rr[idx] to 0 if rr[idx]==count, else rr[idx]+1. Go to RESP.
    - No match, and idx+1 == sched_num_types: set found=0; go to RESP.
    - Otherwise: increment idx; go to READ.
  - RESP: rsp_valid=1 with registered outputs held stable until rsp_ready; on handshake go to IDLE.
- Latency: a hit on entry k gives rsp_valid 2k+3 cycles after the accept edge. A full miss gives rsp_valid 2N+1 cycles after accept, where N = sched_num_types.
- The first match wins; duplicate task types further on are never reached.
- count==0 (single instance): rr stays 0 and the same id is always returned.
- rr is updated once per hit, at the CHECK edge, not at the response handshake.
- sched_ready falling mid-scan does not affect the request in flight; it only blocks new accepts.
- Back-to-back: req_ready is low in RESP, so a new accept is possible no earlier than the cycle after the response handshake.

Optional Feature:
- Macro: SCHED_LOOKUP_CACHE_EN.
- When defined, a one-entry last-hit cache holds: valid, task type, entry idx, base, count.
  - Cache is written on every CHECK hit.
  - In IDLE, an accepted request whose type equals the cached type with valid=1 skips the scan. The same rr select/update is done using the cached idx, and the block goes to RESP; rsp_valid is 1 cycle after accept.
  - Cache valid is cleared on reset and whenever sched_ready=0.
- When not defined: no cache logic; every request scans from entry 0.

Decomposition:
- OmpSsManager package holds MAX_ACCS and the SCHED_DATA_TASK_TYPE_L/H, SCHED_DATA_COUNT_L and SCHED_DATA_ACCID_L field constants. These are shared with the parse stage.
- The state enum stays local to this module.
- One natural sub-module: sched_rr_counters. It holds the rr array and provides a combined select/update port: input idx, count, base and an advance strobe; output the selected acc_id. This port is reused by the cache path.

Test Plan:
1. Memory {type 5, base 0, count 1}, {type 7, base 2, count 2}; N=2; four requests for type 7 -> acc_ids 2, 3, 4, 2; each rsp_valid 5 cycles after accept (cache off).
2. Same memory; request type 9 -> rsp_found=0, rsp_acc_id=0, rsp_valid 5 cycles after accept.
3. sched_num_types=0 with sched_ready=1; request any type -> rsp_found=0 at accept+1. With sched_ready=0, req_ready stays low and nothing is accepted.
4. Hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_acc_id stay stable and req_ready stays 0. Assert ap_rst mid-scan -> rsp_valid=0 next cycle and rr counters cleared (next type-7 request returns 2).
5. Two entries both type 5 (bases 0 and 8) -> always served from base 0.
6. SCHED_LOOKUP_CACHE_EN: type 7 requested twice -> second response at accept+1 with id 3. Drop sched_ready for one cycle, then request type 7 -> full scan latency of 5 cycles and id 4.
